ori_mem_arb: RTL
================

# ori_mem_arb

Single-port SRAM arbiter for the Ori system RAM, shared between the video fetch engine and the 8080 CPU bus. Grants one access at a time, sequences SRAM strobes with a programmable wait count, and returns read data with a one-cycle acknowledge pulse. Drives the CPU READY line low while a CPU request is pending, stretching the 8080 bus cycle until its access completes.

## Interface
- `AW`, 16, address width
- `SRAM_WAIT`, 1, extra strobe cycles per access (0..3)

- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, synchronous, active-high
- `vid_req_i`  in  1  video read request, level, held until ack
- `vid_addr_i`  in  AW  video read address
- `vid_ack_o`  out  1  one-cycle pulse, `vid_data_o` valid
- `vid_data_o`  out  8  video read data
- `cpu_req_i`  in  1  CPU access request, level, held until ack
- `cpu_we_i`  in  1  1 = write, 0 = read; stable while `cpu_req_i` high
- `cpu_addr_i`  in  AW  CPU address
- `cpu_data_i`  in  8  CPU write data
- `cpu_data_o`  out  8  CPU read data, valid with `cpu_ack_o`
- `cpu_ack_o`  out  1  one-cycle completion pulse
- `cpu_ready_o`  out  1  8080 READY; low while `cpu_req_i & ~cpu_ack_o`
- `sram_addr_o`  out  AW  SRAM address
- `sram_data_o`  out  8  SRAM write data
- `sram_data_i`  in  8  SRAM read data
- `sram_oe_o`  out  1  output enable, active-high
- `sram_we_o`  out  1  write enable, active-high

## Operation
- FSM states: IDLE, ACC, END.
- IDLE: if any request is high, choose the winner (see Configuration). Latch address, direction, write data and owner into registers, load the wait counter with `SRAM_WAIT`, go to ACC. Otherwise stay in IDLE.
- ACC:
  - `sram_addr_o` comes from the latched address.
  - Read: `sram_oe_o` = 1. Write: `sram_we_o` = 1 and `sram_data_o` = latched data.
  - If the counter is 0, sample `sram_data_i` into the owner's data register and go to END. Otherwise decrement the counter.
- END:
  - Strobes are low.
  - The owner's ack is high for exactly this cycle. The data register holds its value until the owner's next access.
  - Go to IDLE.
- Video accesses are always reads; the video port ignores `cpu_we_i`.
- Requesters must deassert their request on the clock edge that ends the END cycle, so the request is low in the following IDLE cycle.
- Requests are sampled only in IDLE. Changes during ACC and END are ignored.
- `cpu_ready_o` is combinational from `cpu_req_i` and the registered `cpu_ack_o`.

## Timing
- Reset values: state IDLE, all acks 0, `sram_oe_o`/`sram_we_o` 0, `sram_addr_o` 0, `sram_data_o` 0, data registers 0, fairness pointer = CPU-next.
- Latency: request seen in IDLE at cycle 0 → ack in cycle `SRAM_WAIT`+2.
- Strobe width: `SRAM_WAIT`+1 cycles.
- Back-to-back throughput: one access per `SRAM_WAIT`+3 cycles.
- Strobes never overlap. There is at least one strobe-free cycle (END) between accesses.
- Simultaneous requests in IDLE: exactly one grant. The loser waits in IDLE and is granted in the next IDLE.
- Reset asserted mid-access: on the next edge the state is IDLE and strobes are low. No ack is issued for the aborted access.
- `SRAM_WAIT` values outside 0..3 are an elaboration error.

## Configuration
- `ORI_ARB_FAIR_EN` defined: round-robin arbitration.
  - If both requests are high in IDLE, the side named by the fairness pointer wins.
  - The pointer flips to the other side after every grant.
  - A single requester always wins regardless of the pointer.
- Not defined: strict priority. Video always wins over CPU, and the fairness pointer is not built.

## Structure
- `ori_pkg` holds:
  - the state enum (IDLE/ACC/END)
  - owner encoding (OWN_VID, OWN_CPU)
  - the `SRAM_WAIT` maximum constant
- One sub-module, `ori_arb_pick`: combinational winner selection from both requests and the fairness pointer, plus the registered pointer update under `ORI_ARB_FAIR_EN`.
- FSM, counter and SRAM drive stay in `ori_mem_arb`.

## Test plan
- CPU read, `SRAM_WAIT`=1, addr 0x1234, SRAM returns 0xA5 → `sram_oe_o` high 2 cycles, `cpu_ack_o` pulses in cycle 3, `cpu_data_o`=0xA5, `cpu_ready_o` low cycles 0–2 and high from cycle 3.
- CPU write 0x5A to 0xF800, `SRAM_WAIT`=0 → `sram_we_o` high 1 cycle with addr 0xF800 and data 0x5A, `cpu_ack_o` in cycle 2, `sram_oe_o` never high.
- Both requests held continuously for 4 grants with `ORI_ARB_FAIR_EN` → grant order CPU, VID, CPU, VID. Without the macro → VID every grant and `cpu_ack_o` never pulses.
- Video read of 0x4000, SRAM returns 0x3C, with a CPU request rising during ACC → video completes with `vid_data_o`=0x3C, then the CPU is granted in the next IDLE.
- `rst_i` pulsed in the second ACC cycle of a CPU read, `SRAM_WAIT`=3 → strobes drop on the next edge, no `cpu_ack_o`, and a new request completes normally.
- Random requests for 10k cycles → `sram_oe_o & sram_we_o` is never high, and every ack pulse matches exactly one grant.

Source files
------------

// File: rtl/ori_pkg.sv
// ori_pkg -- shared types and constants for the Ori system RAM arbiter.
//   state_e  : arbiter FSM states (IDLE / ACC / END)
//   owner_e  : which requester owns the current SRAM access
//   acc_t    : per-access attributes latched at grant time
//   SRAM_WAIT_MAX / WCNT_W : wait-count range and counter width
package ori_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    END  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  // Attributes of the access in flight; the address lives beside it
  // because its width is a module parameter.
  typedef struct packed {
    owner_e     own;
    logic       we;
    logic [7:0] wdata;
  } acc_t;

  localparam int SRAM_WAIT_MAX = 3;
  localparam int WCNT_W        = 2;

endpackage

// File: rtl/ori_arb_pick.sv
// ori_arb_pick -- winner selection between the video fetch and CPU ports.
// Build option: ORI_ARB_FAIR_EN
//   defined   : round-robin; a fairness pointer names the side that wins a
//               tie and flips after every grant (reset value: CPU-next).
//   undefined : strict priority, video always wins a tie; no pointer state.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (pointer only)
//   vid_req_i     video request level
//   cpu_req_i     CPU request level
//   grant_i       arbiter is granting this cycle (advances the pointer)
//   win_o         owner of the grant (combinational)
module ori_arb_pick
  import ori_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   vid_req_i,
  input  logic   cpu_req_i,
  input  logic   grant_i,
  output owner_e win_o
);

`ifdef ORI_ARB_FAIR_EN
  owner_e ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)        ptr_q <= OWN_CPU;
    else if (grant_i) ptr_q <= (ptr_q == OWN_CPU) ? OWN_VID : OWN_CPU;
  end

  // A lone requester wins; the pointer only breaks ties.
  always_comb begin
    win_o = OWN_VID;
    if (vid_req_i && cpu_req_i) win_o = ptr_q;
    else if (cpu_req_i)         win_o = OWN_CPU;
  end
`else
  // No pointer in strict-priority builds; clock/reset/grant are unused.
  logic unused_fair;
  assign unused_fair = ^{clk_i, rst_i, grant_i};

  always_comb begin
    win_o = OWN_VID;
    if (cpu_req_i && !vid_req_i) win_o = OWN_CPU;
  end
`endif

endmodule

// File: rtl/ori_mem_arb.sv
// ori_mem_arb -- single-port SRAM arbiter for the Ori system RAM.
// Shares one SRAM between the video fetch engine (reads only) and the 8080
// CPU bus. One access at a time: IDLE (grant) -> ACC (strobe, SRAM_WAIT+1
// cycles) -> END (strobes low, one-cycle ack) -> IDLE.
// Build option: ORI_ARB_FAIR_EN selects round-robin instead of video-first
// arbitration (see ori_arb_pick).
// Parameters: AW address width, SRAM_WAIT extra strobe cycles (0..3).
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   vid_req_i/vid_addr_i            video read request (level, held to ack)
//   vid_ack_o/vid_data_o            video ack pulse and read data
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i  CPU request
//   cpu_data_o/cpu_ack_o            CPU read data and ack pulse
//   cpu_ready_o                     8080 READY, low while CPU waits
//   sram_addr_o/sram_data_o/sram_data_i/sram_oe_o/sram_we_o  SRAM side
module ori_mem_arb
  import ori_pkg::*;
#(
  parameter int AW        = 16,
  parameter int SRAM_WAIT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  output logic          vid_ack_o,
  output logic [7:0]    vid_data_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_data_i,
  output logic [7:0]    cpu_data_o,
  output logic          cpu_ack_o,
  output logic          cpu_ready_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [7:0]    sram_data_o,
  input  logic [7:0]    sram_data_i,
  output logic          sram_oe_o,
  output logic          sram_we_o
);

  if (SRAM_WAIT < 0 || SRAM_WAIT > SRAM_WAIT_MAX) begin : g_bad_wait
    $error("ori_mem_arb: SRAM_WAIT must be within 0..3");
  end

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(SRAM_WAIT);

  state_e            state_q, state_d;
  acc_t              acc_q;
  logic [AW-1:0]     addr_q;
  logic [WCNT_W-1:0] cnt_q;
  logic              vid_ack_q, cpu_ack_q;
  logic [7:0]        vid_data_q, cpu_data_q;

  owner_e win;
  logic   any_req, grant, done;

  assign any_req = vid_req_i | cpu_req_i;
  assign grant   = (state_q == IDLE) & any_req;
  // Last strobe cycle: SRAM data is sampled on the edge that ends it.
  assign done    = (state_q == ACC) & (cnt_q == '0);

  ori_arb_pick u_pick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .vid_req_i (vid_req_i),
    .cpu_req_i (cpu_req_i),
    .grant_i   (grant),
    .win_o     (win)
  );

  // Next state and SRAM strobes.
  always_comb begin
    state_d     = state_q;
    sram_oe_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_data_o = '0;
    unique case (state_q)
      IDLE: if (any_req) state_d = ACC;
      ACC: begin
        sram_oe_o = ~acc_q.we;
        sram_we_o = acc_q.we;
        if (acc_q.we) sram_data_o = acc_q.wdata;
        if (cnt_q == '0) state_d = END;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Access latch, wait counter, acks and per-owner data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '{own: OWN_VID, we: 1'b0, wdata: 8'h00};
      addr_q     <= '0;
      cnt_q      <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
    end else begin
      if (grant) begin
        acc_q.own   <= win;
        // Video is read-only, so cpu_we_i only matters for a CPU grant.
        acc_q.we    <= (win == OWN_CPU) & cpu_we_i;
        acc_q.wdata <= cpu_data_i;
        addr_q      <= (win == OWN_CPU) ? cpu_addr_i : vid_addr_i;
        cnt_q       <= WAIT_LD;
      end else if (state_q == ACC && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      vid_ack_q <= done & (acc_q.own == OWN_VID);
      cpu_ack_q <= done & (acc_q.own == OWN_CPU);

      if (done && acc_q.own == OWN_VID) vid_data_q <= sram_data_i;
      // The SRAM bus is not driven during a write, so a CPU write leaves
      // the CPU read register with its previous read value.
      if (done && acc_q.own == OWN_CPU && !acc_q.we) cpu_data_q <= sram_data_i;
    end
  end

  assign sram_addr_o = addr_q;
  assign vid_ack_o   = vid_ack_q;
  assign vid_data_o  = vid_data_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_data_o  = cpu_data_q;
  assign cpu_ready_o = ~(cpu_req_i & ~cpu_ack_q);

endmodule
